// File: rtl/axi_line_write_master_if.sv
// AXI4 write-channel bundle (AW, W, B) between the line write master and the interconnect.
interface axi_line_write_master_if #(
    parameter int ID_WIDTH = 4
);
    logic [ID_WIDTH-1:0] awid;
    logic [31:0]         awaddr;
    logic [7:0]          awlen;
    logic [2:0]          awsize;
    logic [1:0]          awburst;
    logic                awvalid;
    logic                awready;

    logic [31:0]         wdata;
    logic [3:0]          wstrb;
    logic                wlast;
    logic                wvalid;
    logic                wready;

    logic [ID_WIDTH-1:0] bid;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready
    );
endinterface

// File: rtl/axi_line_write_master.sv
// Writes one 256-bit cache line as an 8-beat 32-bit AXI INCR burst and pulses valid_o on the B response.
// Optional sticky error flag err_o when built with AXI_LINE_WRITE_ERR_EN.
module axi_line_write_master #(
    parameter int ID_WIDTH = 4,
    parameter int AW_ID    = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wen_i,
    input  logic [255:0]            wdata_i,
    input  logic [31:0]             waddr_i,
    output logic                    valid_o,
    output logic                    busy_o,
    output logic [2:0]              dbg_state_o,
`ifdef AXI_LINE_WRITE_ERR_EN
    output logic                    err_o,
`endif
    axi_line_write_master_if.master axi
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_AW   = 3'd1,
        S_W    = 3'd2,
        S_B    = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t       state_q, state_d;
    logic [2:0]   beat_q, beat_d;
    logic [255:0] line_q, line_d;
    logic [31:0]  addr_q, addr_d;

    // Handshakes: a transfer happens on a rising clk edge where valid && ready are both high;
    // once raised, awvalid/wvalid stay high with address/data unchanged until that edge.

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            beat_q  <= 3'd0;
            line_q  <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            line_q  <= line_d;
            addr_q  <= addr_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        line_d      = line_q;
        addr_d      = addr_q;
        axi.awvalid = 1'b0;
        axi.wvalid  = 1'b0;
        axi.wlast   = 1'b0;
        axi.bready  = 1'b0;
        valid_o     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (wen_i) begin
                    line_d  = wdata_i;
                    addr_d  = {waddr_i[31:5], 5'b0};
                    state_d = S_AW;
                end
            end
            S_AW: begin
                axi.awvalid = 1'b1;
                if (axi.awready) begin
                    beat_d  = 3'd0;
                    state_d = S_W;
                end
            end
            S_W: begin
                axi.wvalid = 1'b1;
                axi.wlast  = (beat_q == 3'd7);
                if (axi.wready) begin
                    beat_d = beat_q + 3'd1;
                    if (beat_q == 3'd7) begin
                        state_d = S_B;
                    end
                end
            end
            S_B: begin
                axi.bready = 1'b1;
                if (axi.bvalid) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                // The buffer drops its entry on this pulse, so no accept is allowed here.
                valid_o = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign axi.awid    = ID_WIDTH'(AW_ID);
    assign axi.awaddr  = addr_q;
    assign axi.awlen   = 8'd7;
    assign axi.awsize  = 3'b010;
    assign axi.awburst = 2'b01;
    assign axi.wstrb   = 4'hF;
    assign axi.wdata   = line_q[{beat_q, 5'b0} +: 32];

    assign busy_o      = (state_q != S_IDLE);
    assign dbg_state_o = state_q;

    logic unused_addr_bits;
    assign unused_addr_bits = ^waddr_i[4:0];

`ifdef AXI_LINE_WRITE_ERR_EN
    logic err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (axi.bvalid && axi.bready &&
                     (axi.bresp != 2'b00 || axi.bid != ID_WIDTH'(AW_ID))) begin
            err_q <= 1'b1;
        end
    end

    assign err_o = err_q;
`else
    logic unused_b_bits;
    assign unused_b_bits = ^{axi.bid, axi.bresp};
`endif

endmodule
